// File: rtl/demux_1x8_8b_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x8_8b_reg_pkg
// Description : Shared constants and types for the registered 1-to-8
//               write-side distributor.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_1x8_8b_reg_pkg;

  // Number of holding channels and width of a channel index
  localparam int CH_COUNT = 8;
  localparam int SEL_W    = 3;

  // Default value loaded into every channel on reset and on clear
  localparam logic [7:0] RESET_VAL_DFLT = 8'h00;

  // Control state: normal write service, or the sequenced clear
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage : demux_1x8_8b_reg_pkg
`default_nettype wire

// File: rtl/demux_1x8_8b_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x8_8b_reg_if
// Description : Write handshake, clear control and holding-register outputs
//               of the 1-to-8 distributor. The master side is the writer and
//               consumer of the channel outputs; the slave side is the
//               distributor itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1x8_8b_reg_if
  import demux_1x8_8b_reg_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  // Write side
  logic [WIDTH-1:0]    d;
  logic [SEL_W-1:0]    sel;
  logic                auto_mode;
  logic                in_valid;
  logic                in_ready;
  logic                clr;

  // Holding registers, one per channel
  logic [WIDTH-1:0]    q0;
  logic [WIDTH-1:0]    q1;
  logic [WIDTH-1:0]    q2;
  logic [WIDTH-1:0]    q3;
  logic [WIDTH-1:0]    q4;
  logic [WIDTH-1:0]    q5;
  logic [WIDTH-1:0]    q6;
  logic [WIDTH-1:0]    q7;

  // Status
  logic [CH_COUNT-1:0] wr_stb;
  logic [SEL_W-1:0]    ptr;
  logic                clearing;

  modport master (
    output d, sel, auto_mode, in_valid, clr,
    input  in_ready,
    input  q0, q1, q2, q3, q4, q5, q6, q7,
    input  wr_stb, ptr, clearing
  );

  modport slave (
    input  d, sel, auto_mode, in_valid, clr,
    output in_ready,
    output q0, q1, q2, q3, q4, q5, q6, q7,
    output wr_stb, ptr, clearing
  );

endinterface : demux_1x8_8b_reg_if
`default_nettype wire

// File: rtl/demux_1x8_8b_reg_dec.sv
`default_nettype none
// ============================================================================
// Module      : dec_3to8
// Description : Combinational 3-to-8 one-hot decoder with enable. All outputs
//               are zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_3to8
  import demux_1x8_8b_reg_pkg::*;
(
  input  logic                i_en,
  input  logic [SEL_W-1:0]    i_idx,
  output logic [CH_COUNT-1:0] o_onehot
);

  // Raise the single bit addressed by i_idx when enabled
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule : dec_3to8
`default_nettype wire

// File: rtl/demux_1x8_8b_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x8_8b_reg
// Description : Registered 1-to-8 write-side distributor. Each accepted word
//               is stored into one of eight holding registers, chosen by sel
//               or by an auto-incrementing pointer. A clear request walks a
//               counter through all eight channels, one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x8_8b_reg
  import demux_1x8_8b_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DFLT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_1x8_8b_reg_if.slave    bus
);

  localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(CH_COUNT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    r_clr_cnt;
  logic [SEL_W-1:0]    w_target;
  logic [CH_COUNT-1:0] w_wr_oh;
  logic [CH_COUNT-1:0] w_clr_oh;
  logic [CH_COUNT-1:0] r_wr_stb;
  logic                w_in_ready;
  logic                w_clearing;
  logic                w_clr_start;
  logic                w_clr_done;
  logic                w_accept;
  logic [WIDTH-1:0]    w_q [CH_COUNT];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; clr wins over a simultaneous write
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_clearing  = 1'b0;
    w_clr_start = 1'b0;
    w_clr_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = !bus.clr;
        if (bus.clr) begin
          w_clr_start = 1'b1;
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        w_clearing = 1'b1;
        if (r_clr_cnt == c_LAST_CH) begin
          w_clr_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_target = bus.auto_mode ? r_ptr : bus.sel;

  // Write-enable decode for the accepted word
  dec_3to8 u_dec_wr (
    .i_en     (w_accept),
    .i_idx    (w_target),
    .o_onehot (w_wr_oh)
  );

  // Channel selection for the clear walk
  dec_3to8 u_dec_clr (
    .i_en     (w_clearing),
    .i_idx    (r_clr_cnt),
    .o_onehot (w_clr_oh)
  );

  // Clear counter: restarts on entry, steps once per CLEAR cycle, wraps to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if (w_clr_start) begin
      r_clr_cnt <= '0;
    end else if (w_clearing) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Auto pointer: post-increment on auto-mode accepts, zeroed when clear ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_clr_done) begin
      r_ptr <= '0;
    end else if (w_accept && bus.auto_mode) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  // Write strobe: one-cycle pulse aligned with the holding-register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_stb <= '0;
    end else begin
      r_wr_stb <= w_wr_oh;
    end
  end

  // Holding registers; clear and write never target a channel together
  // because writes are only accepted outside the clear sequence
  generate
    for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_ch
      logic [WIDTH-1:0] r_q;

      // Per-channel holding register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= RESET_VAL;
        end else if (w_clr_oh[gi]) begin
          r_q <= RESET_VAL;
        end else if (w_wr_oh[gi]) begin
          r_q <= bus.d;
        end
      end

      assign w_q[gi] = r_q;
    end
  endgenerate

  assign bus.in_ready = w_in_ready;
  assign bus.clearing = w_clearing;
  assign bus.ptr      = r_ptr;
  assign bus.wr_stb   = r_wr_stb;
  assign bus.q0       = w_q[0];
  assign bus.q1       = w_q[1];
  assign bus.q2       = w_q[2];
  assign bus.q3       = w_q[3];
  assign bus.q4       = w_q[4];
  assign bus.q5       = w_q[5];
  assign bus.q6       = w_q[6];
  assign bus.q7       = w_q[7];

endmodule : demux_1x8_8b_reg
`default_nettype wire

// File: tb/tb_demux_1x8_8b_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x8_8b_reg
// Description : Self-checking bench for the 1-to-8 distributor. Directed
//               scenarios followed by random traffic, compared cycle by cycle
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x8_8b_reg;

  localparam logic [7:0] c_RV = 8'h00;

  logic clk;
  logic rst_n;

  demux_1x8_8b_reg_if #(.WIDTH(8)) bus ();

  demux_1x8_8b_reg #(.WIDTH(8), .RESET_VAL(c_RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: channel contents, pointer, last strobe, clear cycles left
  logic [7:0] m_q [8];
  logic [2:0] m_ptr;
  logic [7:0] m_stb;
  int         m_left;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_q(input int i);
    case (i)
      0: return bus.q0;
      1: return bus.q1;
      2: return bus.q2;
      3: return bus.q3;
      4: return bus.q4;
      5: return bus.q5;
      6: return bus.q6;
      default: return bus.q7;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_q[i] = c_RV;
    m_ptr  = 3'd0;
    m_stb  = 8'h00;
    m_left = 0;
  endtask

  // One rising edge of the reference model, using the inputs now applied
  task automatic model_edge();
    int t;
    if (m_left > 0) begin
      m_q[8 - m_left] = c_RV;
      m_left--;
      m_stb = 8'h00;
      if (m_left == 0) m_ptr = 3'd0;
    end else if (bus.clr) begin
      m_left = 8;
      m_stb  = 8'h00;
    end else if (bus.in_valid) begin
      t = bus.auto_mode ? int'(m_ptr) : int'(bus.sel);
      m_q[t] = bus.d;
      m_stb  = 8'(1 << t);
      if (bus.auto_mode) m_ptr = 3'((m_ptr + 1) % 8);
    end else begin
      m_stb = 8'h00;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 8; i++) check($sformatf("q%0d", i), dut_q(i), m_q[i]);
    check("wr_stb", bus.wr_stb, m_stb);
    check("ptr", bus.ptr, m_ptr);
    check("clearing", bus.clearing, (m_left > 0));
  endtask

  // Called just after a falling edge with inputs applied; returns at the
  // next falling edge with outputs checked
  task automatic step();
    #1;
    check("in_ready", bus.in_ready, (m_left == 0) && !bus.clr);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  int n_clr;

  initial begin
    rst_n         = 1'b0;
    bus.d         = 8'h00;
    bus.sel       = 3'd0;
    bus.auto_mode = 1'b0;
    bus.in_valid  = 1'b0;
    bus.clr       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check("ready_in_reset", bus.in_ready, 1'b1);
    rst_n = 1'b1;

    // Manual writes on consecutive cycles
    bus.in_valid = 1'b1;
    bus.sel = 3'd5; bus.d = 8'hA5;
    step();
    check("man_q5", bus.q5, 8'hA5);
    check("man_stb5", bus.wr_stb, 8'b0010_0000);
    bus.sel = 3'd0; bus.d = 8'h3C;
    step();
    check("man_q0", bus.q0, 8'h3C);
    check("man_stb0", bus.wr_stb, 8'b0000_0001);
    check("man_ptr", bus.ptr, 3'd0);

    // Auto sequence with wrap back to channel 0
    bus.auto_mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.d = 8'(8'h10 + i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("auto_q0", bus.q0, 8'h18);
    check("auto_q7", bus.q7, 8'h17);
    check("auto_ptr", bus.ptr, 3'd1);

    // Clear collides with a write; the write is held through the clear
    bus.auto_mode = 1'b0; bus.sel = 3'd3; bus.d = 8'h77;
    bus.in_valid = 1'b1; bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    n_clr = int'(bus.clearing);
    for (int i = 0; i < 8; i++) begin
      step();
      n_clr += int'(bus.clearing);
    end
    check("clear_len", n_clr, 8);
    step();
    check("held_q3", bus.q3, 8'h77);
    check("held_stb", bus.wr_stb, 8'b0000_1000);
    bus.in_valid = 1'b0;

    // Refill, then reset during the fourth clear cycle
    bus.auto_mode = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.d = 8'($urandom_range(255)) | 8'h80;
      step();
    end
    bus.in_valid = 1'b0; bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 8; i++) check($sformatf("arst_q%0d", i), dut_q(i), c_RV);
    check("arst_clearing", bus.clearing, 1'b0);
    check("arst_stb", bus.wr_stb, 8'h00);
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    // Hold-off: write held through a clear, clr re-pulsed mid-sequence
    bus.auto_mode = 1'b0; bus.sel = 3'd6; bus.d = 8'h5A;
    bus.in_valid = 1'b1; bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    repeat (3) step();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    repeat (3) step();
    check("hold_still_clearing", bus.clearing, 1'b1);
    step();
    check("hold_done", bus.clearing, 1'b0);
    step();
    check("hold_q6", bus.q6, 8'h5A);
    check("hold_stb", bus.wr_stb, 8'b0100_0000);
    bus.in_valid = 1'b0;
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.d         = 8'($urandom_range(255));
      bus.sel       = 3'($urandom_range(7));
      bus.auto_mode = 1'($urandom_range(1));
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.clr       = ($urandom_range(15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_demux_1x8_8b_reg
`default_nettype wire

// File: doc/demux_1x8_8b_reg.md
Name: demux_1x8_8b_reg

Overview:
- Registered 1-to-8 write-side distributor: accepts one WIDTH-bit word per handshake and stores it into one of eight holding registers q0..q7.
- q0..q7 are the eight data sources that feed the team's 8:1 byte selector on the read side.
- Channel chosen directly by sel, or by an internal auto-incrementing pointer.
- Includes a sequenced 8-cycle clear.

Parameters:
- WIDTH, 8, data width of d and q0..q7.
- RESET_VAL, 8'h00, value loaded into q0..q7 on reset and on clear.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- d  input  WIDTH  write data.
- sel  input  3  target channel when auto_mode=0.
- auto_mode  input  1  1 = target is ptr, with post-increment.
- in_valid  input  1  write request.
- in_ready  output  1  write can be accepted this cycle.
- clr  input  1  request the sequenced clear of all channels.
- q0..q7  output  WIDTH each  holding registers, one port per channel.
- wr_stb  output  8  one-hot, one-cycle pulse marking the channel just written.
- ptr  output  3  current auto-increment pointer.
- clearing  output  1  high while the clear sequence runs.

Behaviour:
- Reset, async on rst_n low:
  - q0..q7 = RESET_VAL, wr_stb = 0, ptr = 0, state = IDLE, clear counter = 0, clearing = 0.
  - Reset takes effect immediately, including mid-clear; the sequence aborts and every register is at its reset value.
- in_ready = (state==IDLE) && !clr. This is combinational from state and clr.
- Accept: in_valid && in_ready at a rising edge.
  - target = auto_mode ? ptr : sel.
  - q[target] <= d on that edge; new value visible in the following cycle.
  - wr_stb <= onehot(target), registered. High exactly one cycle, aligned with the q update; all zero otherwise.
- ptr:
  - Increments by 1, modulo 8, only on an accept with auto_mode=1; 7 wraps to 0.
  - Accepts with auto_mode=0 leave ptr unchanged.
  - auto_mode is sampled only at the accept edge.
- Back-to-back accepts are allowed every cycle (throughput 1 word/cycle). The same channel written on consecutive cycles takes the last value.
- State machine:
  - IDLE: clr=1 -> CLEAR with counter=0, no write accepted (clr has priority over a simultaneous in_valid); otherwise writes as above.
  - CLEAR: each cycle q[counter] <= RESET_VAL, counter++.
  - Clear order: first edge after entry clears q0, eighth edge clears q7.
  - After the q7 edge -> IDLE, ptr <= 0, counter <= 0. CLEAR lasts exactly 8 cycles.
- In CLEAR:
  - clearing=1 and in_ready=0.
  - clr is ignored (no restart).
  - in_valid is ignored; the source must hold it.
  - wr_stb stays 0 for clear writes.
- Unwritten channels keep their values indefinitely; there is no implicit clear.
- No combinational path from d to any q output.

Decomposition:
- Shared package holds:
  - CH_COUNT=8 and SEL_W=3.
  - State enum {IDLE, CLEAR}.
  - RESET_VAL default.
- Natural sub-module: dec_3to8, a combinational 3-to-8 one-hot decoder.
  - Drives the per-channel write enables and the D input of wr_stb.
  - Reused for the clear counter index.

Test Plan:
- Reset, then manual writes: auto_mode=0, writes (sel=5,d=8'hA5) and then (sel=0,d=8'h3C) on consecutive cycles.
  - Required: q5=A5 and q0=3C one cycle after their edges; wr_stb=8'b0010_0000 then 8'b0000_0001; the other q stay 00; ptr=0.
- Auto sequence: auto_mode=1, 9 accepts with d=8'h10..8'h18.
  - Required: q0..q7 = 18,11,12,13,14,15,16,17 (channel 0 rewritten after the wrap); ptr ends at 1.
- Clear collision: clr=1 and in_valid=1 in the same cycle.
  - Required: in_ready=0, no write, clearing=1 for exactly 8 cycles, q0..q7 go to RESET_VAL in order q0->q7, ptr=0 afterwards.
  - Required: a write held pending is accepted on the first IDLE cycle.
- Reset mid-clear: assert rst_n=0 asynchronously during the 4th CLEAR cycle.
  - Required: all q=RESET_VAL, clearing=0 and wr_stb=0 immediately without waiting for a clock; state returns to IDLE with in_ready=1 after release.
- Hold-off: in_valid held through a CLEAR; clr pulsed again mid-sequence.
  - Required: sequence not restarted (still 8 cycles total); held write lands after exit; wr_stb pulses once.
